store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter BITS_SIZE, default 32, store data bus width in bits (multiple of 16, at least 32).
REQ-002 Parameter BITS_ADDR, default 32, byte address width.
REQ-003 Parameter BITS_EXTENSION, default 2, width of the store-size selector.
REQ-004 Port i_clk  input  1  single clock, all state updates on its rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_valid  input  1  store request present.
REQ-007 Port o_ready  output  1  unit accepts a request this cycle.
REQ-008 Port i_addr  input  BITS_ADDR  byte address (base+offset).
REQ-009 Port i_dato_rt  input  BITS_SIZE  REG[rt] store source.
REQ-010 Port i_ctl_select  input  BITS_EXTENSION  size: 00 full bus word, 01 SB, 10 SH, 11 reserved.
REQ-011 Port o_mem_valid  output  1  memory write beat valid.
REQ-012 Port i_mem_ready  input  1  memory accepts the beat.
REQ-013 Port o_mem_addr  output  BITS_ADDR  bus-aligned beat address.
REQ-014 Port o_mem_data  output  BITS_SIZE  lane-positioned write data.
REQ-015 Port o_mem_be  output  BITS_SIZE/8  byte enables.
REQ-016 Port o_exc  output  1  one-cycle store exception pulse.

Function
REQ-017 FSM states IDLE, BEAT0, BEAT1; o_ready SHALL equal (state == IDLE).
REQ-018 Accept when i_valid and o_ready: register address, data and size; go to BEAT0 next cycle, unless the request is an exception (REQ-024), which stays in IDLE.
REQ-019 Size in bytes: 1 (01), 2 (10), BITS_SIZE/8 (00); offset = i_addr modulo BITS_SIZE/8.
REQ-020 BEAT0 outputs: address = i_addr with offset bits cleared; data = size-masked rt shifted left by 8*offset; be = size mask shifted left by offset, truncated to bus width.
REQ-021 Split condition: offset + size > BITS_SIZE/8; BEAT1 address = BEAT0 address + BITS_SIZE/8; data = masked rt shifted right by 8*(BITS_SIZE/8 - offset); be = mask shifted right by same byte count.
REQ-022 o_mem_valid = 1 in BEAT0 and BEAT1; all o_mem_* outputs SHALL be registered and held stable while i_mem_ready = 0.
REQ-023 In BEAT0 with i_mem_ready: go to BEAT1 if split, else IDLE; in BEAT1 with i_mem_ready: go to IDLE. A new request is accepted no earlier than the cycle after return to IDLE (no back-to-back overlap).
REQ-024 i_ctl_select = 11 on accept: o_exc pulses one cycle after accept, no memory beat, state remains IDLE.
REQ-025 Unused upper bytes of o_mem_data (be = 0) SHALL be zero.

Reset
REQ-026 On i_rst_n = 0, immediately: state IDLE, o_mem_valid 0, o_exc 0, o_mem_addr/data/be all zero; o_ready 1 after release.
REQ-027 Reset during BEAT0 or BEAT1 SHALL abandon the store; no beat is reissued after release.

Configuration
REQ-028 Macro STORE_MISALIGN_SPLIT_EN defined: split stores execute as two beats per REQ-021.
REQ-029 Macro undefined: a split-condition request SHALL raise o_exc per REQ-024 timing, issue no beat, and BEAT1 state SHALL not be built.

Structure
REQ-030 Shared package holds the size encodings (SEL_WORD 00, SEL_BYTE 01, SEL_HALF 10, SEL_RSVD 11) and state encoding constants.
REQ-031 One sub-module store_lane_shift (combinational: size, offset, data -> beat0/beat1 data and be) is natural; FSM stays in the top.

Verification (BITS_SIZE = 32)
REQ-032 SW addr 0x100, rt 0xDEADBEEF -> one beat addr 0x100, be 1111, data 0xDEADBEEF, o_mem_valid one cycle after accept.
REQ-033 SB addr 0x103, rt 0x12345678 -> addr 0x100, be 1000, data 0x78000000.
REQ-034 SH addr 0x103, rt 0xAABBCCDD, macro on -> beat0 addr 0x100 be 1000 data 0xDD000000, beat1 addr 0x104 be 0001 data 0x000000CC; macro off -> o_exc pulse, no o_mem_valid.
REQ-035 SW addr 0x200 with i_mem_ready low 3 cycles -> o_mem_* stable all 3 cycles, o_ready 0, returns IDLE cycle after ready.
REQ-036 i_ctl_select 11 -> o_exc one pulse, o_mem_valid never set; i_rst_n low during BEAT1 of REQ-034 -> outputs zero at once, no beat after release.

Source files
------------

// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment unit: store-size selector values
// and FSM state constants.
package store_align_unit_pkg;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_BYTE = 2'b01;
  localparam logic [1:0] SEL_HALF = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BEAT0 = 2'b01;
  localparam logic [1:0] ST_BEAT1 = 2'b10;

endpackage

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane placement of a store: masks rt to the store size and
// positions data/byte-enables for the first and (STORE_MISALIGN_SPLIT_EN) second beat.
module store_lane_shift
  import store_align_unit_pkg::*;
#(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_EXTENSION = 2,
  parameter int OFFW           = 2
) (
  input  logic [BITS_EXTENSION-1:0] sel_i,
  input  logic [OFFW-1:0]           offset_i,
  input  logic [BITS_SIZE-1:0]      data_i,
  output logic [BITS_SIZE-1:0]      beat0_data_o,
  output logic [BITS_SIZE/8-1:0]    beat0_be_o,
`ifdef STORE_MISALIGN_SPLIT_EN
  output logic [BITS_SIZE-1:0]      beat1_data_o,
  output logic [BITS_SIZE/8-1:0]    beat1_be_o,
`endif
  output logic                      split_o
);

  localparam int NB  = BITS_SIZE / 8;
  localparam int SZW = OFFW + 2;

  logic [BITS_SIZE-1:0] masked_s;
  logic [NB-1:0]        mask_be_s;
  logic [SZW-1:0]       size_bytes_s;

  // Size decode: reserved encodings fall to full width and are trapped by the top.
  always_comb begin
    case (sel_i)
      SEL_BYTE: begin
        masked_s     = {{(BITS_SIZE-8){1'b0}}, data_i[7:0]};
        mask_be_s    = {{(NB-1){1'b0}}, 1'b1};
        size_bytes_s = SZW'(32'd1);
      end
      SEL_HALF: begin
        masked_s     = {{(BITS_SIZE-16){1'b0}}, data_i[15:0]};
        mask_be_s    = {{(NB-2){1'b0}}, 2'b11};
        size_bytes_s = SZW'(32'd2);
      end
      default: begin
        masked_s     = data_i;
        mask_be_s    = {NB{1'b1}};
        size_bytes_s = SZW'(NB);
      end
    endcase
  end

  assign split_o = (SZW'(offset_i) + size_bytes_s) > SZW'(NB);

`ifdef STORE_MISALIGN_SPLIT_EN
  // Shifting into a double-width vector makes the upper half the spill-over beat.
  logic [2*BITS_SIZE-1:0] ext_data_s;
  logic [2*NB-1:0]        ext_be_s;

  assign ext_data_s   = {{BITS_SIZE{1'b0}}, masked_s} << {offset_i, 3'b000};
  assign ext_be_s     = {{NB{1'b0}}, mask_be_s} << offset_i;
  assign beat0_data_o = ext_data_s[BITS_SIZE-1:0];
  assign beat1_data_o = ext_data_s[2*BITS_SIZE-1:BITS_SIZE];
  assign beat0_be_o   = ext_be_s[NB-1:0];
  assign beat1_be_o   = ext_be_s[2*NB-1:NB];
`else
  assign beat0_data_o = masked_s << {offset_i, 3'b000};
  assign beat0_be_o   = mask_be_s << offset_i;
`endif

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts one store, emits one or two registered memory
// write beats. Split (misaligned) stores are executed only with STORE_MISALIGN_SPLIT_EN.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_ADDR      = 32,
  parameter int BITS_EXTENSION = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [BITS_ADDR-1:0]      i_addr,
  input  logic [BITS_SIZE-1:0]      i_dato_rt,
  input  logic [BITS_EXTENSION-1:0] i_ctl_select,
  output logic                      o_mem_valid,
  input  logic                      i_mem_ready,
  output logic [BITS_ADDR-1:0]      o_mem_addr,
  output logic [BITS_SIZE-1:0]      o_mem_data,
  output logic [BITS_SIZE/8-1:0]    o_mem_be,
  output logic                      o_exc
);

  localparam int NB   = BITS_SIZE / 8;
  localparam int OFFW = (NB > 1) ? $clog2(NB) : 1;

  logic [OFFW-1:0]      offset_s;
  logic [BITS_ADDR-1:0] base_addr_s;
  logic [BITS_SIZE-1:0] beat0_data_s;
  logic [NB-1:0]        beat0_be_s;
  logic                 split_s;
  logic                 exc_s;

  logic [1:0]           state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [BITS_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [BITS_SIZE-1:0] mem_data_q, mem_data_d;
  logic [NB-1:0]        mem_be_q, mem_be_d;
  logic                 exc_q, exc_d;

  assign offset_s    = OFFW'(i_addr % BITS_ADDR'(NB));
  assign base_addr_s = i_addr - BITS_ADDR'(offset_s);

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [BITS_SIZE-1:0] beat1_data_s;
  logic [NB-1:0]        beat1_be_s;
  logic                 split_q, split_d;
  logic [BITS_ADDR-1:0] b1_addr_q, b1_addr_d;
  logic [BITS_SIZE-1:0] b1_data_q, b1_data_d;
  logic [NB-1:0]        b1_be_q, b1_be_d;

  assign exc_s = (i_ctl_select == SEL_RSVD);
`else
  assign exc_s = (i_ctl_select == SEL_RSVD) || split_s;
`endif

  store_lane_shift #(
    .BITS_SIZE      (BITS_SIZE),
    .BITS_EXTENSION (BITS_EXTENSION),
    .OFFW           (OFFW)
  ) u_lane_shift (
    .sel_i        (i_ctl_select),
    .offset_i     (offset_s),
    .data_i       (i_dato_rt),
    .beat0_data_o (beat0_data_s),
    .beat0_be_o   (beat0_be_s),
`ifdef STORE_MISALIGN_SPLIT_EN
    .beat1_data_o (beat1_data_s),
    .beat1_be_o   (beat1_be_s),
`endif
    .split_o      (split_s)
  );

  // Beat outputs are loaded on state transitions so they stay put under back-pressure.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_be_d    = mem_be_q;
    exc_d       = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    split_d     = split_q;
    b1_addr_d   = b1_addr_q;
    b1_data_d   = b1_data_q;
    b1_be_d     = b1_be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (exc_s) begin
            exc_d = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = base_addr_s;
            mem_data_d  = beat0_data_s;
            mem_be_d    = beat0_be_s;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_d     = split_s;
            b1_addr_d   = base_addr_s + BITS_ADDR'(NB);
            b1_data_d   = beat1_data_s;
            b1_be_d     = beat1_be_s;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (i_mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
          if (split_q) begin
            state_d    = ST_BEAT1;
            mem_addr_d = b1_addr_q;
            mem_data_d = b1_data_q;
            mem_be_d   = b1_be_q;
          end else begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_data_d  = '0;
            mem_be_d    = '0;
          end
`else
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_data_d  = '0;
          mem_be_d    = '0;
`endif
        end else begin
          state_d = ST_BEAT0;
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        if (i_mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_data_d  = '0;
          mem_be_d    = '0;
        end else begin
          state_d = ST_BEAT1;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
        mem_be_d    = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_be_q    <= '0;
      exc_q       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      b1_addr_q   <= '0;
      b1_data_q   <= '0;
      b1_be_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_be_q    <= mem_be_d;
      exc_q       <= exc_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q     <= split_d;
      b1_addr_q   <= b1_addr_d;
      b1_data_q   <= b1_data_d;
      b1_be_q     <= b1_be_d;
`endif
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_mem_be    = mem_be_q;
  assign o_exc       = exc_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit (32-bit bus); follows STORE_MISALIGN_SPLIT_EN.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_dato_rt = 32'd0;
  logic [1:0]  i_ctl_select = 2'b00;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [3:0]  o_mem_be;
  logic        o_exc;

  int checks = 0;
  int failures = 0;

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  store_align_unit #(.BITS_SIZE(32), .BITS_ADDR(32), .BITS_EXTENSION(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_dato_rt(i_dato_rt), .i_ctl_select(i_ctl_select),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_be(o_mem_be), .o_exc(o_exc)
  );

  // Byte-by-byte reference: each stored byte lands in the word holding its address.
  function automatic bit model(input logic [31:0] addr, input logic [31:0] rt, input logic [1:0] sel);
    int size;
    beat_t b0, b1;
    bit use_b1;
    logic [31:0] ba;
    size = (sel == 2'd1) ? 1 : (sel == 2'd2) ? 2 : 4;
    if (sel == 2'd3) return 1'b1;
    if ((addr % 4) + size > 4 && !SPLIT_EN) return 1'b1;
    b0.addr = addr & 32'hFFFF_FFFC; b0.data = 32'd0; b0.be = 4'd0;
    b1.addr = b0.addr + 32'd4;      b1.data = 32'd0; b1.be = 4'd0;
    use_b1 = 1'b0;
    for (int i = 0; i < size; i++) begin
      ba = addr + i;
      if ((ba & 32'hFFFF_FFFC) == b0.addr) begin
        b0.data = b0.data | (((rt >> (8 * i)) & 32'hFF) << (8 * (ba % 4)));
        b0.be[ba % 4] = 1'b1;
      end else begin
        b1.data = b1.data | (((rt >> (8 * i)) & 32'hFF) << (8 * (ba % 4)));
        b1.be[ba % 4] = 1'b1;
        use_b1 = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (use_b1) exp_q.push_back(b1);
    return 1'b0;
  endfunction

  // mode 0: always ready, 1: random ready, 2: ready low 3 cycles then high
  task automatic do_store(input logic [31:0] addr, input logic [31:0] rt, input logic [1:0] sel,
                          input bit exp_exc, input int mode, input string name);
    int cyc;
    int hold;
    bit rdy;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_pre got=%b exp=1", name, o_ready);
    end
    i_valid = 1'b1; i_addr = addr; i_dato_rt = rt; i_ctl_select = sel;
    @(negedge clk);
    i_valid = 1'b0; i_addr = $urandom; i_dato_rt = $urandom; i_ctl_select = 2'($urandom_range(0, 3));
    if (exp_exc) begin
      checks++;
      if (o_exc !== 1'b1 || o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
        failures++; $display("FAIL %s exc_pulse got exc=%b valid=%b ready=%b exp 1/0/1", name, o_exc, o_mem_valid, o_ready);
      end
      @(negedge clk);
      checks++;
      if (o_exc !== 1'b0 || o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
        failures++; $display("FAIL %s exc_end got exc=%b valid=%b ready=%b exp 0/0/1", name, o_exc, o_mem_valid, o_ready);
      end
      exp_q.delete();
    end else begin
      cyc = 0; hold = 0;
      while (exp_q.size() > 0 && cyc < 50) begin
        checks++;
        if (o_mem_valid !== 1'b1 || o_ready !== 1'b0 || o_exc !== 1'b0 ||
            o_mem_addr !== exp_q[0].addr || o_mem_data !== exp_q[0].data || o_mem_be !== exp_q[0].be) begin
          failures++;
          $display("FAIL %s beat got v=%b rdy=%b exc=%b a=%h d=%h be=%b exp v=1 rdy=0 exc=0 a=%h d=%h be=%b",
                   name, o_mem_valid, o_ready, o_exc, o_mem_addr, o_mem_data, o_mem_be,
                   exp_q[0].addr, exp_q[0].data, exp_q[0].be);
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (hold >= 3);
        endcase
        hold++;
        i_mem_ready = rdy;
        if (rdy) void'(exp_q.pop_front());
        cyc++;
        @(negedge clk);
      end
      i_mem_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
        failures++; $display("FAIL %s timeout pending=%0d exp=0", name, exp_q.size());
        exp_q.delete();
      end
      checks++;
      if (o_mem_valid !== 1'b0 || o_ready !== 1'b1 || o_exc !== 1'b0) begin
        failures++; $display("FAIL %s idle got valid=%b ready=%b exc=%b exp 0/1/0", name, o_mem_valid, o_ready, o_exc);
      end
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    beat_t b;
    b.addr = a; b.data = d; b.be = be;
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o_mem_valid !== 1'b0 || o_exc !== 1'b0 || o_mem_addr !== 32'd0 || o_mem_data !== 32'd0 || o_mem_be !== 4'd0) begin
      failures++; $display("FAIL reset_outputs got v=%b e=%b a=%h d=%h be=%b exp all 0", o_mem_valid, o_exc, o_mem_addr, o_mem_data, o_mem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%b valid=%b exp 1/0", o_ready, o_mem_valid);
    end
  endtask

  task automatic test_directed();
    push_beat(32'h100, 32'hDEADBEEF, 4'b1111);
    do_store(32'h100, 32'hDEADBEEF, 2'b00, 1'b0, 0, "sw_aligned");
    push_beat(32'h100, 32'h78000000, 4'b1000);
    do_store(32'h103, 32'h12345678, 2'b01, 1'b0, 0, "sb_lane3");
    if (SPLIT_EN) begin
      push_beat(32'h100, 32'hDD000000, 4'b1000);
      push_beat(32'h104, 32'h000000CC, 4'b0001);
    end
    do_store(32'h103, 32'hAABBCCDD, 2'b10, !SPLIT_EN, 0, "sh_split");
  endtask

  task automatic test_backpressure();
    push_beat(32'h200, 32'h0BADF00D, 4'b1111);
    do_store(32'h200, 32'h0BADF00D, 2'b00, 1'b0, 2, "sw_stall");
  endtask

  task automatic test_reserved();
    do_store(32'h300, 32'h11223344, 2'b11, 1'b1, 0, "rsvd_sel");
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  s;
    bit e;
    for (int n = 0; n < 200; n++) begin
      a = $urandom; d = $urandom; s = 2'($urandom_range(0, 3));
      if (n < 4) a = 32'hFFFF_FFFC + 32'(n);
      e = model(a, d, s);
      do_store(a, d, s, e, 1, "random");
    end
  endtask

  task automatic test_reset_midstore();
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h103; i_dato_rt = 32'hAABBCCDD;
    i_ctl_select = SPLIT_EN ? 2'b10 : 2'b00;
    @(negedge clk);
    i_valid = 1'b0;
    if (SPLIT_EN) begin
      i_mem_ready = 1'b1;
      @(negedge clk);
      i_mem_ready = 1'b0;
      checks++;
      if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h104) begin
        failures++; $display("FAIL rst_mid in_beat1 got v=%b a=%h exp 1/00000104", o_mem_valid, o_mem_addr);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_exc !== 1'b0 || o_mem_addr !== 32'd0 || o_mem_data !== 32'd0 ||
        o_mem_be !== 4'd0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid immediate got v=%b e=%b a=%h d=%h be=%b r=%b exp 0/0/0/0/0/1",
                           o_mem_valid, o_exc, o_mem_addr, o_mem_data, o_mem_be, o_ready);
    end
    i_mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
        failures++; $display("FAIL rst_mid after_release got v=%b r=%b exp 0/1", o_mem_valid, o_ready);
      end
    end
    i_mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reserved();
    test_random();
    test_reset_midstore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
